// File: rtl/input_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | input_unit_pkg: flit layout, routing directions and route helper for the    |
// | router input unit. INPUT_UNIT_TORUS_EN selects wrap-around routing.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package input_unit_pkg;

  localparam int FLIT_SIZE = 16;
  localparam int ROUTE_LEN = 3;
  localparam int COORD_LEN = 2;
  localparam int VC_ID_LEN = 3;
  localparam int DIM_SIZE  = 4;
  localparam int VC_NUM    = 4;

  localparam logic [ROUTE_LEN-1:0] DIR_LOCAL = 3'd0;
  localparam logic [ROUTE_LEN-1:0] DIR_XPOS  = 3'd1;
  localparam logic [ROUTE_LEN-1:0] DIR_XNEG  = 3'd2;
  localparam logic [ROUTE_LEN-1:0] DIR_YPOS  = 3'd3;
  localparam logic [ROUTE_LEN-1:0] DIR_YNEG  = 3'd4;
  localparam logic [ROUTE_LEN-1:0] DIR_ZPOS  = 3'd5;
  localparam logic [ROUTE_LEN-1:0] DIR_ZNEG  = 3'd6;

  localparam int HEAD_BIT  = FLIT_SIZE - 1;
  localparam int TAIL_BIT  = FLIT_SIZE - 2;
  localparam int VC_HI     = FLIT_SIZE - 3;
  localparam int VC_LO     = VC_HI - VC_ID_LEN + 1;
  localparam int DSTZ_LO   = VC_LO - COORD_LEN;
  localparam int DSTY_LO   = DSTZ_LO - COORD_LEN;
  localparam int DSTX_LO   = DSTY_LO - COORD_LEN;
  localparam int PAYLOAD_W = DSTX_LO;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUTE  = 2'd1,
    ST_ACTIVE = 2'd2
  } vc_state_e;

  function automatic logic [ROUTE_LEN-1:0] dim_dir(
    input logic [COORD_LEN-1:0] cur,
    input logic [COORD_LEN-1:0] dst,
    input logic [ROUTE_LEN-1:0] pos,
    input logic [ROUTE_LEN-1:0] neg
  );
`ifdef INPUT_UNIT_TORUS_EN
    logic [COORD_LEN:0] dim_w;
    logic [COORD_LEN:0] d;
    dim_w = (COORD_LEN+1)'(DIM_SIZE);
    // Forward distance around the ring; the shorter way wins, ties go positive.
    d = ({1'b0, dst} + dim_w - {1'b0, cur}) % dim_w;
    return (d <= (dim_w >> 1)) ? pos : neg;
`else
    return (dst > cur) ? pos : neg;
`endif
  endfunction

  function automatic logic [ROUTE_LEN-1:0] compute_route(
    input logic [COORD_LEN-1:0] cur_x,
    input logic [COORD_LEN-1:0] cur_y,
    input logic [COORD_LEN-1:0] cur_z,
    input logic [COORD_LEN-1:0] dst_x,
    input logic [COORD_LEN-1:0] dst_y,
    input logic [COORD_LEN-1:0] dst_z
  );
    if (dst_x != cur_x) return dim_dir(cur_x, dst_x, DIR_XPOS, DIR_XNEG);
    if (dst_y != cur_y) return dim_dir(cur_y, dst_y, DIR_YPOS, DIR_YNEG);
    if (dst_z != cur_z) return dim_dir(cur_z, dst_z, DIR_ZPOS, DIR_ZNEG);
    return DIR_LOCAL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_unit_vc_fifo.sv
// +----------------------------------------------------------------------------+
// | vc_fifo: per-VC flit buffer with show-ahead front output.                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module vc_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] front
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign front     = r_mem[r_rd_ptr];
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_push_ok = push && (!full || pop);
  assign w_pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/input_unit.sv
// +----------------------------------------------------------------------------+
// | input_unit: router input port with per-VC buffering and route latching.     |
// | Define INPUT_UNIT_TORUS_EN for torus routing. Revision: 1.0                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module input_unit
  import input_unit_pkg::*;
#(
  parameter int VC_NUM     = input_unit_pkg::VC_NUM,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COORD_LEN-1:0]          cur_x,
  input  logic [COORD_LEN-1:0]          cur_y,
  input  logic [COORD_LEN-1:0]          cur_z,
  input  logic [FLIT_SIZE-1:0]          in_flit,
  input  logic                          in_valid,
  output logic [VC_NUM-1:0]             credit_out,
  output logic [VC_NUM*FLIT_SIZE-1:0]   out_flit,
  output logic [VC_NUM*ROUTE_LEN-1:0]   out_route,
  output logic [VC_NUM-1:0]             out_valid,
  input  logic [VC_NUM-1:0]             out_avail,
  output logic                          err
);

  logic [VC_ID_LEN-1:0] w_vc_id;
  logic                 w_bad_vc;
  logic [VC_NUM-1:0]    w_pop_vec;
  logic [VC_NUM-1:0]    w_vc_err;
  logic [VC_NUM-1:0]    r_credit;
  logic                 r_err;

  assign w_vc_id  = in_flit[VC_HI:VC_LO];
  assign w_bad_vc = in_valid && (int'(w_vc_id) >= VC_NUM);

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    vc_state_e            r_state;
    vc_state_e            w_state_nxt;
    logic [ROUTE_LEN-1:0] r_route;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [FLIT_SIZE-1:0] w_front;
    logic [FLIT_SIZE-1:0] w_look;

    assign w_push = in_valid && (w_vc_id == VC_ID_LEN'(v));

    vc_fifo #(
      .WIDTH (FLIT_SIZE),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (in_flit),
      .full  (w_full),
      .empty (w_empty),
      .front (w_front)
    );

    // An idle VC inspects the arriving flit directly so a head reaches ROUTE
    // in the cycle it is buffered, giving the two-cycle head latency.
    assign w_look = w_empty ? in_flit : w_front;

    always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_drop      = 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty && !w_front[HEAD_BIT]) begin
            w_pop  = 1'b1;
            w_drop = 1'b1;
          end else if ((!w_empty || w_push) && w_look[HEAD_BIT]) begin
            w_state_nxt = ST_ROUTE;
          end
        end
        ST_ROUTE: w_state_nxt = ST_ACTIVE;
        ST_ACTIVE: begin
          if (!w_empty && out_avail[v]) begin
            w_pop = 1'b1;
            if (w_front[TAIL_BIT]) w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_state <= ST_IDLE;
        r_route <= '0;
      end else begin
        r_state <= w_state_nxt;
        if (r_state == ST_ROUTE) begin
          r_route <= compute_route(cur_x, cur_y, cur_z,
                                   w_front[DSTX_LO +: COORD_LEN],
                                   w_front[DSTY_LO +: COORD_LEN],
                                   w_front[DSTZ_LO +: COORD_LEN]);
        end
      end
    end

    assign w_vc_err[v]  = w_drop || (w_push && w_full && !w_pop);
    assign w_pop_vec[v] = w_pop;
    assign out_valid[v] = (r_state == ST_ACTIVE) && !w_empty;
    assign out_flit[v*FLIT_SIZE +: FLIT_SIZE]  = w_front;
    assign out_route[v*ROUTE_LEN +: ROUTE_LEN] = r_route;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_credit <= '0;
      r_err    <= 1'b0;
    end else begin
      r_credit <= w_pop_vec;
      r_err    <= r_err || w_bad_vc || (|w_vc_err);
    end
  end

  assign credit_out = r_credit;
  assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_input_unit.sv
// +----------------------------------------------------------------------------+
// | tb_input_unit: directed vectors plus a queue-based reference model.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_input_unit;
  import input_unit_pkg::*;

  localparam int DEPTH = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [COORD_LEN-1:0]        cur_x, cur_y, cur_z;
  logic [FLIT_SIZE-1:0]        in_flit;
  logic                        in_valid;
  logic [VC_NUM-1:0]           credit_out;
  logic [VC_NUM*FLIT_SIZE-1:0] out_flit;
  logic [VC_NUM*ROUTE_LEN-1:0] out_route;
  logic [VC_NUM-1:0]           out_valid;
  logic [VC_NUM-1:0]           out_avail;
  logic                        err;

  int n_vec = 0;
  int n_err = 0;

  input_unit #(.VC_NUM(VC_NUM), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .cur_z      (cur_z),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .credit_out (credit_out),
    .out_flit   (out_flit),
    .out_route  (out_route),
    .out_valid  (out_valid),
    .out_avail  (out_avail),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [FLIT_SIZE-1:0] mk(input bit h, input bit t, input int vc,
                                              input int dx, input int dy, input int dz,
                                              input int pl);
    logic [FLIT_SIZE-1:0] f;
    f = '0;
    f[HEAD_BIT] = h;
    f[TAIL_BIT] = t;
    f[VC_HI:VC_LO] = VC_ID_LEN'(vc);
    f[DSTZ_LO +: COORD_LEN] = COORD_LEN'(dz);
    f[DSTY_LO +: COORD_LEN] = COORD_LEN'(dy);
    f[DSTX_LO +: COORD_LEN] = COORD_LEN'(dx);
    f[PAYLOAD_W-1:0] = PAYLOAD_W'(pl);
    return f;
  endfunction

  function automatic logic [ROUTE_LEN-1:0] rt(input int v);
    return out_route[v*ROUTE_LEN +: ROUTE_LEN];
  endfunction

  function automatic logic [FLIT_SIZE-1:0] fl(input int v);
    return out_flit[v*FLIT_SIZE +: FLIT_SIZE];
  endfunction

  // Reference model: buffered flits per VC, packet phase, latched route.
  logic [FLIT_SIZE-1:0] mq [VC_NUM][$];
  int                   mph [VC_NUM];
  logic [ROUTE_LEN-1:0] mroute [VC_NUM];
  logic [VC_NUM-1:0]    mcred;
  logic                 merr;
  bit                   mdl_on = 1'b0;

  task automatic model_step();
    logic [VC_NUM-1:0]    pop;
    logic [FLIT_SIZE-1:0] fr;
    bit                   e;
    bit                   here;
    int                   id;
    e = merr;
    for (int v = 0; v < VC_NUM; v++) begin
      pop[v] = 1'b0;
      fr = (mq[v].size() > 0) ? mq[v][0] : '0;
      here = in_valid && (int'(in_flit[VC_HI:VC_LO]) == v);
      if (mph[v] == 0) begin
        if (mq[v].size() > 0 && !fr[HEAD_BIT]) begin
          pop[v] = 1'b1;
          e = 1'b1;
        end else if ((mq[v].size() > 0 && fr[HEAD_BIT]) ||
                     (mq[v].size() == 0 && here && in_flit[HEAD_BIT])) begin
          mph[v] = 1;
        end
      end else if (mph[v] == 1) begin
        mroute[v] = compute_route(cur_x, cur_y, cur_z, fr[DSTX_LO +: COORD_LEN],
                                  fr[DSTY_LO +: COORD_LEN], fr[DSTZ_LO +: COORD_LEN]);
        mph[v] = 2;
      end else if (mq[v].size() > 0 && out_avail[v]) begin
        pop[v] = 1'b1;
        if (fr[TAIL_BIT]) mph[v] = 0;
      end
      if (pop[v]) void'(mq[v].pop_front());
    end
    if (in_valid) begin
      id = int'(in_flit[VC_HI:VC_LO]);
      if (id >= VC_NUM) e = 1'b1;
      else if (mq[id].size() == DEPTH) e = 1'b1;
      else mq[id].push_back(in_flit);
    end
    mcred = pop;
    merr  = e;
  endtask

  always @(negedge clk) begin
    if (mdl_on) begin
      for (int v = 0; v < VC_NUM; v++) begin
        bit ev;
        ev = (mph[v] == 2) && (mq[v].size() > 0);
        chk($sformatf("mdl_valid[%0d]", v), 64'(out_valid[v]), 64'(ev));
        chk($sformatf("mdl_route[%0d]", v), 64'(rt(v)), 64'(mroute[v]));
        chk($sformatf("mdl_credit[%0d]", v), 64'(credit_out[v]), 64'(mcred[v]));
        if (ev) chk($sformatf("mdl_flit[%0d]", v), 64'(fl(v)), 64'(mq[v][0]));
      end
      chk("mdl_err", 64'(err), 64'(merr));
    end
    if (rst !== 1'b1) begin
      for (int v = 0; v < VC_NUM; v++) begin
        mq[v].delete();
        mph[v] = 0;
        mroute[v] = '0;
      end
      mcred  = '0;
      merr   = 1'b0;
      mdl_on = 1'b1;
    end else if (mdl_on) begin
      model_step();
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [FLIT_SIZE-1:0] f);
    in_flit  = f;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FLIT_SIZE-1:0] f;
    logic [PAYLOAD_W-1:0] got [4];
    int                   n;
    rst = 1'b0; in_valid = 1'b0; in_flit = '0; out_avail = '0;
    cur_x = 2'd1; cur_y = 2'd1; cur_z = 2'd1;
    tick(2);
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_credit", 64'(credit_out), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_route", 64'(out_route), 64'(0));
    rst = 1'b1;
    tick(1);

    // Single head+tail flit: valid two cycles after write, credit one after pop.
    out_avail = '1;
    f = mk(1, 1, 0, 3, 1, 1, 7);
    send(f);
    chk("ht_valid_t1", 64'(out_valid[0]), 64'(0));
    tick(1);
    chk("ht_valid_t2", 64'(out_valid[0]), 64'(1));
    chk("ht_route", 64'(rt(0)), 64'(DIR_XPOS));
    chk("ht_flit", 64'(fl(0)), 64'(f));
    tick(1);
    chk("ht_credit", 64'(credit_out[0]), 64'(1));
    chk("ht_valid_t3", 64'(out_valid[0]), 64'(0));
    tick(1);
    chk("ht_credit_end", 64'(credit_out[0]), 64'(0));

    // Three-flit packet held by backpressure, then drained.
    out_avail = '0;
    send(mk(1, 0, 1, 1, 0, 1, 1));
    send(mk(0, 0, 1, 1, 0, 1, 2));
    send(mk(0, 1, 1, 1, 0, 1, 3));
    tick(2);
    chk("pkt_route_held", 64'(rt(1)), 64'(DIR_YNEG));
    chk("pkt_valid_held", 64'(out_valid[1]), 64'(1));
    out_avail = '1;
    n = 0;
    repeat (6) begin
      if (out_valid[1]) n++;
      tick(1);
    end
    chk("pkt_xfers", 64'(n), 64'(3));
    chk("pkt_route_after", 64'(rt(1)), 64'(DIR_YNEG));
    chk("pkt_valid_after", 64'(out_valid[1]), 64'(0));

    // Overflow: fifth flit dropped, four delivered intact.
    do_reset();
    out_avail = '0;
    send(mk(1, 0, 0, 2, 2, 2, 1));
    send(mk(0, 0, 0, 2, 2, 2, 2));
    send(mk(0, 0, 0, 2, 2, 2, 3));
    send(mk(0, 0, 0, 2, 2, 2, 4));
    send(mk(0, 1, 0, 2, 2, 2, 5));
    tick(1);
    chk("ovf_err", 64'(err), 64'(1));
    out_avail = '1;
    n = 0;
    repeat (8) begin
      if (out_valid[0] && n < 4) begin
        got[n] = fl(0)[PAYLOAD_W-1:0];
        n++;
      end
      tick(1);
    end
    chk("ovf_count", 64'(n), 64'(4));
    for (int i = 0; i < 4; i++) chk($sformatf("ovf_payload%0d", i), 64'(got[i]), 64'(i + 1));
    send(mk(0, 1, 0, 2, 2, 2, 6));
    tick(3);

    // Body flit into an idle VC is discarded with a credit and an error.
    do_reset();
    send(mk(0, 0, 3, 1, 1, 1, 9));
    tick(1);
    chk("orphan_credit", 64'(credit_out[3]), 64'(1));
    chk("orphan_err", 64'(err), 64'(1));
    chk("orphan_valid", 64'(out_valid[3]), 64'(0));
    send(mk(1, 1, 3, 1, 1, 0, 10));
    tick(1);
    chk("orphan_next_valid", 64'(out_valid[3]), 64'(1));
    chk("orphan_next_route", 64'(rt(3)), 64'(DIR_ZNEG));
    tick(2);

    // VC id outside the configured range.
    do_reset();
    send(mk(1, 1, 5, 2, 1, 1, 11));
    chk("badvc_err", 64'(err), 64'(1));
    tick(2);
    chk("badvc_valid", 64'(out_valid), 64'(0));

    // Wrap-around distance on X.
    rst = 1'b0;
    cur_x = 2'd0;
    tick(1);
    rst = 1'b1;
    send(mk(1, 1, 0, 3, 1, 1, 12));
    tick(1);
`ifdef INPUT_UNIT_TORUS_EN
    chk("torus_route", 64'(rt(0)), 64'(DIR_XNEG));
`else
    chk("mesh_route", 64'(rt(0)), 64'(DIR_XPOS));
`endif
    tick(2);
    rst = 1'b0;
    cur_x = 2'd1;
    tick(1);
    rst = 1'b1;

    // Reset in the middle of a packet on VC2.
    out_avail = '0;
    send(mk(1, 0, 2, 2, 1, 1, 13));
    send(mk(0, 0, 2, 2, 1, 1, 14));
    tick(1);
    do_reset();
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_credit", 64'(credit_out), 64'(0));
    chk("midrst_err", 64'(err), 64'(0));
    chk("midrst_route", 64'(out_route), 64'(0));
    out_avail = '1;
    send(mk(1, 1, 2, 1, 2, 1, 15));
    tick(1);
    chk("midrst_next_valid", 64'(out_valid[2]), 64'(1));
    chk("midrst_next_route", 64'(rt(2)), 64'(DIR_YPOS));
    tick(1);
    chk("midrst_next_credit", 64'(credit_out[2]), 64'(1));

    // All VCs pop together.
    do_reset();
    out_avail = '0;
    for (int v = 0; v < VC_NUM; v++) send(mk(1, 1, v, 3, 1, 1, 16 + v));
    tick(3);
    chk("all_valid", 64'(out_valid), 64'(4'hF));
    out_avail = '1;
    tick(1);
    chk("all_credit", 64'(credit_out), 64'(4'hF));
    chk("all_valid_after", 64'(out_valid), 64'(0));

    // Write into a full FIFO in the same cycle as a pop is accepted.
    do_reset();
    out_avail = '0;
    send(mk(1, 0, 1, 2, 1, 1, 1));
    send(mk(0, 0, 1, 2, 1, 1, 2));
    send(mk(0, 0, 1, 2, 1, 1, 3));
    send(mk(0, 0, 1, 2, 1, 1, 4));
    out_avail = '1;
    send(mk(0, 0, 1, 2, 1, 1, 5));
    send(mk(0, 1, 1, 2, 1, 1, 6));
    tick(6);
    chk("fullpop_err", 64'(err), 64'(0));
    chk("fullpop_valid", 64'(out_valid[1]), 64'(0));

    tick(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
